// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution result path:
//   - FIFO command encodings driven by the convolution controller
//   - default width of one convolution result word
//   - drain FSM state type used by conv_result_fifo
// -----------------------------------------------------------------------------
package conv_pkg;

  // Default width of one result word produced by the final adder stage.
  localparam int CONV_RESULT_W = 20;

  // Controller command encodings (level-held on fifo_command).
  localparam logic [1:0] FIFO_CMD_IDLE  = 2'b00;
  localparam logic [1:0] FIFO_CMD_WRITE = 2'b10;
  localparam logic [1:0] FIFO_CMD_READ  = 2'b01;
  localparam logic [1:0] FIFO_CMD_CLEAR = 2'b11;

  // Output-side state: idle, or streaming the stored words out.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/result_fifo_mem.sv
// -----------------------------------------------------------------------------
// result_fifo_mem
// DEPTH x DATA_W storage array for conv_result_fifo. One synchronous write
// port and one asynchronous read port, so a RAM macro with the same port
// behaviour can be dropped in. Contents are not reset.
// Ports:
//   clk    in   clock, write happens on the rising edge
//   we     in   write enable
//   waddr  in   write address (ADDR_W)
//   wdata  in   write data (DATA_W)
//   raddr  in   read address (ADDR_W)
//   rdata  out  combinational read data (DATA_W)
// -----------------------------------------------------------------------------
module result_fifo_mem #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_result_fifo.sv
// -----------------------------------------------------------------------------
// conv_result_fifo
// Output buffer behind the convolution datapath. Each write command captures
// one result word; a read command drains every stored word over a
// valid/ready stream; a clear command discards everything.
//
// fifo_command is level-held by the controller, so only a change to a
// non-idle code counts as an event (one event per command, however long it
// is held).
//
// Optional build macro: CONV_RESULT_FIFO_PARITY_EN
//   When defined each entry carries an even-parity bit, checked on every
//   transfer; a mismatch sets the sticky parity_err output.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   fifo_command  in   00 idle, 10 write, 01 drain, 11 clear
//   wr_data       in   result word, sampled on a write event
//   out_ready     in   downstream accepts the current word
//   out_valid     out  out_data holds a valid word
//   out_data      out  drained word (registered)
//   out_last      out  current word is the final word of the drain
//   drain_done    out  one-cycle pulse after the last word transfers
//   full          out  count == DEPTH
//   empty         out  count == 0
//   count         out  occupied entries
//   overflow      out  sticky: a write was dropped while full
//   parity_err    out  (parity build only) sticky parity mismatch
// -----------------------------------------------------------------------------
module conv_result_fifo
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_RESULT_W,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        fifo_command,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              drain_done,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
`ifdef CONV_RESULT_FIFO_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef CONV_RESULT_FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef CONV_RESULT_FIFO_PARITY_EN
  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // State registers
  logic [1:0]        cmd_prev_q,  cmd_prev_d;
  fifo_state_e       state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic              drain_done_q, drain_done_d;
  logic              full_q,      full_d;
  logic              empty_q,     empty_d;
  logic              overflow_q,  overflow_d;
`ifdef CONV_RESULT_FIFO_PARITY_EN
  logic              out_par_q,    out_par_d;
  logic              parity_err_q, parity_err_d;
`endif

  // Combinational helpers
  logic              cmd_event_s;
  logic              clr_ev_s;
  logic              wr_ev_s;
  logic              rd_ev_s;
  logic              xfer_s;
  logic              wr_ok_s;
  logic              mem_we_s;
  logic [MEM_W-1:0]  mem_wdata_s;
  logic [ADDR_W-1:0] mem_raddr_s;
  logic [MEM_W-1:0]  mem_rdata_s;
  logic [DATA_W-1:0] rd_word_s;

  result_fifo_mem #(
    .DATA_W (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata_s),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  // Edge-qualified command decode; the codes are mutually exclusive.
  always_comb begin
    cmd_event_s = (fifo_command != cmd_prev_q) && (fifo_command != FIFO_CMD_IDLE);
    clr_ev_s    = cmd_event_s && (fifo_command == FIFO_CMD_CLEAR);
    wr_ev_s     = cmd_event_s && (fifo_command == FIFO_CMD_WRITE);
    rd_ev_s     = cmd_event_s && (fifo_command == FIFO_CMD_READ);
    xfer_s      = (state_q == ST_DRAIN) && out_valid_q && out_ready;
  end

  // Memory port wiring. While draining, the register already holds the word
  // at rd_ptr, so the read port looks one entry ahead for the next load.
  always_comb begin
`ifdef CONV_RESULT_FIFO_PARITY_EN
    mem_wdata_s = {even_parity(wr_data), wr_data};
`else
    mem_wdata_s = wr_data;
`endif
    if (state_q == ST_DRAIN) begin
      mem_raddr_s = rd_ptr_q + PTR_ONE;
    end else begin
      mem_raddr_s = rd_ptr_q;
    end
    rd_word_s = mem_rdata_s[DATA_W-1:0];
  end

  // Next-state logic: clear > write > drain, plus the drain FSM.
  always_comb begin
    cmd_prev_d   = fifo_command;
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;
    drain_done_d = 1'b0;
    mem_we_s     = 1'b0;
    wr_ok_s      = 1'b0;
`ifdef CONV_RESULT_FIFO_PARITY_EN
    out_par_d    = out_par_q;
    parity_err_d = parity_err_q;
`endif

    if (clr_ev_s) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      count_d     = CNT_ZERO;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
`ifdef CONV_RESULT_FIFO_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end else begin
      // Write side: legal in either state, dropped when full.
      if (wr_ev_s) begin
        if (full_q) begin
          overflow_d = 1'b1;
        end else begin
          mem_we_s = 1'b1;
          wr_ok_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end else begin
        mem_we_s = 1'b0;
      end

`ifdef CONV_RESULT_FIFO_PARITY_EN
      if (xfer_s && (even_parity(out_data_q) != out_par_q)) begin
        parity_err_d = 1'b1;
      end else begin
        parity_err_d = parity_err_q;
      end
`endif

      // Read side.
      case (state_q)
        ST_IDLE: begin
          if (rd_ev_s && !empty_q) begin
            state_d     = ST_DRAIN;
            out_valid_d = 1'b1;
            out_data_d  = rd_word_s;
`ifdef CONV_RESULT_FIFO_PARITY_EN
            out_par_d   = mem_rdata_s[DATA_W];
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (xfer_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            // out_last_q tracks count_q == 1, i.e. this is the final word.
            if (out_last_q) begin
              state_d      = ST_IDLE;
              out_valid_d  = 1'b0;
              drain_done_d = 1'b1;
            end else begin
              out_data_d = rd_word_s;
`ifdef CONV_RESULT_FIFO_PARITY_EN
              out_par_d  = mem_rdata_s[DATA_W];
`endif
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase

      // A write and a transfer in the same cycle cancel in the count.
      case ({wr_ok_s, xfer_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Recomputed every cycle so a word written mid-drain moves the last flag.
    out_last_d = out_valid_d && (count_d == CNT_ONE);
    full_d     = (count_d == FULL_CNT);
    empty_d    = (count_d == CNT_ZERO);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_prev_q   <= FIFO_CMD_IDLE;
      state_q      <= ST_IDLE;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_last_q   <= 1'b0;
      drain_done_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
`ifdef CONV_RESULT_FIFO_PARITY_EN
      out_par_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      cmd_prev_q   <= cmd_prev_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      drain_done_q <= drain_done_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
`ifdef CONV_RESULT_FIFO_PARITY_EN
      out_par_q    <= out_par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign drain_done = drain_done_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
`ifdef CONV_RESULT_FIFO_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_conv_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_conv_result_fifo
// Directed, self-checking bench for conv_result_fifo. A table of per-cycle
// vectors covers write-then-drain and the level-held command; hand-written
// sequences cover full/overflow with wrap, backpressure, write during drain,
// clear mid-drain and reset mid-drain.
// -----------------------------------------------------------------------------
module tb_conv_result_fifo;

  localparam int DATA_W = 20;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic [1:0]        fifo_command;
  logic [DATA_W-1:0] wr_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              drain_done;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
`ifdef CONV_RESULT_FIFO_PARITY_EN
  logic              parity_err;
`endif

  int total;
  int bad;

  conv_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_command (fifo_command),
    .wr_data      (wr_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .drain_done   (drain_done),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
`ifdef CONV_RESULT_FIFO_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [19:0] wd;
    logic        rdy;
    logic        e_valid;
    logic [19:0] e_data;
    logic        e_last;
    logic        e_done;
    logic [8:0]  e_count;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, sample just after the next rising edge.
  task automatic step(input logic [1:0] c, input logic [19:0] d, input logic r);
    @(negedge clk);
    fifo_command = c;
    wr_data      = d;
    out_ready    = r;
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic [1:0] c, input logic [19:0] d, input logic r,
                     input logic ev, input logic [19:0] ed, input logic el,
                     input logic edn, input logic [8:0] ec, input logic ee);
    vec_t v;
    v.cmd = c; v.wd = d; v.rdy = r;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_done = edn;
    v.e_count = ec; v.e_empty = ee;
    vecs.push_back(v);
  endtask

  task automatic write_word(input logic [19:0] d);
    step(2'b10, d, 1'b0);
    step(2'b00, 20'h0, 1'b0);
  endtask

  task automatic do_clear();
    step(2'b11, 20'h0, 1'b0);
    step(2'b00, 20'h0, 1'b0);
  endtask

  initial begin
    int n;
    int guard;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    fifo_command = 2'b00;
    wr_data   = 20'h0;
    out_ready = 1'b0;
    step(2'b00, 20'h0, 1'b0);
    step(2'b00, 20'h0, 1'b0);

    // Reset state
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_done", int'(drain_done), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;

    // ---- Table: write-then-drain, then level-held write -----------------
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++)
        add(2'b10, 20'h00011 * 20'(w + 1), 1'b0, 0, 0, 0, 0, 9'(w + 1), 0);
      add(2'b00, 20'h0, 1'b0, 0, 0, 0, 0, 9'(w + 1), 0);
    end
    add(2'b01, 20'h0, 1'b1, 1, 20'h00011, 0, 0, 9'd3, 0);
    add(2'b01, 20'h0, 1'b1, 1, 20'h00022, 0, 0, 9'd2, 0);
    add(2'b01, 20'h0, 1'b1, 1, 20'h00033, 1, 0, 9'd1, 0);
    add(2'b01, 20'h0, 1'b1, 0, 20'h0, 0, 1, 9'd0, 1);
    add(2'b00, 20'h0, 1'b1, 0, 20'h0, 0, 0, 9'd0, 1);
    for (int k = 0; k < 10; k++)
      add(2'b10, 20'h00055, 1'b0, 0, 0, 0, 0, 9'd1, 0);
    add(2'b11, 20'h0, 1'b0, 0, 0, 0, 0, 9'd0, 1);
    add(2'b00, 20'h0, 1'b0, 0, 0, 0, 0, 9'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cmd, vecs[i].wd, vecs[i].rdy);
      check("tbl_valid", int'(out_valid), int'(vecs[i].e_valid));
      check("tbl_last", int'(out_last), int'(vecs[i].e_last));
      check("tbl_done", int'(drain_done), int'(vecs[i].e_done));
      check("tbl_count", int'(count), int'(vecs[i].e_count));
      check("tbl_empty", int'(empty), int'(vecs[i].e_empty));
      if (vecs[i].e_valid)
        check("tbl_data", int'(out_data), int'(vecs[i].e_data));
    end

    // ---- Full / overflow / wrap-around ---------------------------------
    for (int i = 0; i < DEPTH; i++) begin
      write_word(20'(i) ^ 20'hA5000);
      if (i == DEPTH - 2) check("full_at_255", int'(full), 0);
    end
    check("full_at_256", int'(full), 1);
    check("count_256", int'(count), 256);
    check("ovf_before", int'(overflow), 0);
    write_word(20'hFFFFF);
    check("ovf_set", int'(overflow), 1);
    check("count_after_drop", int'(count), 256);
    step(2'b01, 20'h0, 1'b1);
    n = 0;
    guard = 0;
    while (out_valid && guard < 400) begin
      check("wrap_data", int'(out_data), int'(20'(n) ^ 20'hA5000));
      check("wrap_last", int'(out_last), int'(n == DEPTH - 1));
      n++;
      guard++;
      step(2'b01, 20'h0, 1'b1);
    end
    check("wrap_words", n, DEPTH);
    check("wrap_done", int'(drain_done), 1);
    check("wrap_empty", int'(empty), 1);
    check("ovf_sticky", int'(overflow), 1);

    // ---- Clear mid-drain (overflow still set from above) ---------------
    write_word(20'h00101);
    write_word(20'h00102);
    step(2'b01, 20'h0, 1'b0);
    check("clr_pre_valid", int'(out_valid), 1);
    step(2'b11, 20'h0, 1'b1);
    check("clr_valid", int'(out_valid), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_overflow", int'(overflow), 0);
    check("clr_last", int'(out_last), 0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 20'h0, 1'b1);
      check("clr_no_done", int'(drain_done), 0);
      check("clr_no_valid", int'(out_valid), 0);
    end

    // ---- Backpressure --------------------------------------------------
    write_word(20'h1234A);
    write_word(20'h1234B);
    step(2'b01, 20'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 32'h1234A);
      check("bp_last", int'(out_last), 0);
      step(2'b00, 20'h0, 1'b0);
    end
    step(2'b00, 20'h0, 1'b1);
    check("bp_data2", int'(out_data), 32'h1234B);
    check("bp_last2", int'(out_last), 1);
    check("bp_valid2", int'(out_valid), 1);
    step(2'b00, 20'h0, 1'b1);
    check("bp_end_valid", int'(out_valid), 0);
    check("bp_done", int'(drain_done), 1);
    check("bp_empty", int'(empty), 1);

    // ---- Write coinciding with the first transfer ----------------------
    write_word(20'h00111);
    write_word(20'h00222);
    step(2'b01, 20'h0, 1'b1);
    check("wd_first", int'(out_data), 32'h00111);
    step(2'b10, 20'hABCDE, 1'b1);
    check("wd_count", int'(count), 2);
    check("wd_second", int'(out_data), 32'h00222);
    check("wd_last_a", int'(out_last), 0);
    step(2'b00, 20'h0, 1'b1);
    check("wd_third", int'(out_data), 32'hABCDE);
    check("wd_last_b", int'(out_last), 1);
    check("wd_count1", int'(count), 1);
    step(2'b00, 20'h0, 1'b1);
    check("wd_done", int'(drain_done), 1);
    check("wd_empty", int'(empty), 1);

    // ---- Reset mid-drain -----------------------------------------------
    write_word(20'h00777);
    write_word(20'h00888);
    step(2'b01, 20'h0, 1'b0);
    check("rmd_pre_valid", int'(out_valid), 1);
    reset = 1'b1;
    step(2'b00, 20'h0, 1'b1);
    reset = 1'b0;
    check("rmd_valid", int'(out_valid), 0);
    check("rmd_empty", int'(empty), 1);
    check("rmd_count", int'(count), 0);
    check("rmd_overflow", int'(overflow), 0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 20'h0, 1'b1);
      check("rmd_no_done", int'(drain_done), 0);
      check("rmd_no_valid", int'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
